// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock (BIN_W cycles after accept).
// Output is held in DONE until out_ready; in_ready only in IDLE. Optional BIN2BCD_SIGNED_EN: two's-complement input, sign on out_neg.
module bin2bcd_seq #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      in_bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  out_neg
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    // 10^DIGITS is built up only until it exceeds the largest input, so it never overflows.
    function automatic bit cfg_ok();
        longint unsigned maxv;
        longint unsigned p;
        maxv = (64'(1) << BIN_W) - 64'(1);
        p    = 64'(1);
        for (int i = 0; i < DIGITS; i++) begin
            if (p <= maxv) p = p * 64'(10);
        end
        return (p > maxv);
    endfunction

    localparam bit CFG_OK = (BIN_W >= 1) && (BIN_W <= 32) && cfg_ok();

    generate
        if (!CFG_OK) begin : g_cfg_err
            $error("bin2bcd_seq: DIGITS too small for BIN_W, or BIN_W outside 1..32");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state;
    logic [BIN_W-1:0]   shift_q;
    logic [BCD_W-1:0]   bcd_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [BCD_W-1:0]   bcd_adj;
    logic [BCD_W-1:0]   bcd_nxt;
    logic [BIN_W-1:0]   load_val;

    assign in_ready = (state == IDLE);

    always_comb begin
        bcd_adj = bcd_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
        end
    end

    assign bcd_nxt = {bcd_adj[BCD_W-2:0], shift_q[BIN_W-1]};

`ifdef BIN2BCD_SIGNED_EN
    logic [BIN_W:0] ext_bin;
    logic [BIN_W:0] mag;
    logic           sign_q;
    logic           neg_q;

    // The extra bit keeps -2^(BIN_W-1) exact; its magnitude still fits in BIN_W bits.
    assign ext_bin  = {in_bin[BIN_W-1], in_bin};
    assign mag      = ext_bin[BIN_W] ? (~ext_bin + 1'b1) : ext_bin;
    assign load_val = mag[BIN_W-1:0];
    assign out_neg  = neg_q;
`else
    assign load_val = in_bin;
    assign out_neg  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shift_q   <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            out_valid <= 1'b0;
            out_bcd   <= '0;
`ifdef BIN2BCD_SIGNED_EN
            sign_q    <= 1'b0;
            neg_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        shift_q <= load_val;
                        bcd_q   <= '0;
                        cnt_q   <= CNT_W'(BIN_W);
`ifdef BIN2BCD_SIGNED_EN
                        sign_q  <= in_bin[BIN_W-1];
`endif
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd_q   <= bcd_nxt;
                    shift_q <= shift_q << 1;
                    cnt_q   <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        out_bcd   <= bcd_nxt;
                        out_valid <= 1'b1;
`ifdef BIN2BCD_SIGNED_EN
                        neg_q     <= sign_q;
`endif
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: 16-bit/5-digit main instance plus a 4-bit/2-digit sweep instance.
module tb_bin2bcd_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_bin;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] out_bcd;
    logic        out_neg;

    logic        s_in_valid;
    logic        s_in_ready;
    logic [3:0]  s_in_bin;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [7:0]  s_out_bcd;
    logic        s_out_neg;

    int n_cmp = 0;
    int n_bad = 0;

    bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_bin(in_bin),
        .out_valid(out_valid), .out_ready(out_ready), .out_bcd(out_bcd), .out_neg(out_neg)
    );

    bin2bcd_seq #(.BIN_W(4), .DIGITS(2)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_bin(s_in_bin),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_bcd(s_out_bcd), .out_neg(s_out_neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Decimal reference: {neg, 5 BCD digits} for a w-bit input.
    function automatic logic [20:0] ref_conv(input longint unsigned v, input int w);
        logic            neg;
        longint unsigned m;
        logic [19:0]     r;
        neg = 1'b0;
        m   = v;
`ifdef BIN2BCD_SIGNED_EN
        if (((v >> (w - 1)) & 64'(1)) != 0) begin
            neg = 1'b1;
            m   = (64'(1) << w) - v;
        end
`endif
        r = '0;
        for (int k = 0; k < 5; k++) begin
            r[4*k +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return {neg, r};
    endfunction

    task automatic accept(input logic [15:0] v);
        in_bin   = v;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("accept_in_ready_low", 32'(in_ready), 32'd0);
    endtask

    // Called right after the accept edge: checks the exact 16-cycle latency and the result.
    task automatic finish(input string tag, input logic [19:0] exp_bcd, input logic exp_neg);
        tick(15);
        check({tag, "_not_early"}, 32'(out_valid), 32'd0);
        tick();
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_bcd"}, 32'(out_bcd), 32'(exp_bcd));
        check({tag, "_neg"}, 32'(out_neg), 32'(exp_neg));
    endtask

    initial begin
        logic [20:0] r;
        logic [15:0] v;
        logic        seen;

        rst_n       = 1'b0;
        in_valid    = 1'b1;
        in_bin      = 16'd5;
        out_ready   = 1'b1;
        s_in_valid  = 1'b0;
        s_in_bin    = 4'd0;
        s_out_ready = 1'b1;

        // Reset held 3 cycles with in_valid high
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_in_ready", 32'(in_ready), 32'd1);
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_out_bcd", 32'(out_bcd), 32'h0);
            check("rst_out_neg", 32'(out_neg), 32'd0);
        end
        rst_n = 1'b1;
        accept(16'd5);
        finish("first", 20'h00005, 1'b0);
        tick();
        check("first_handshake_valid", 32'(out_valid), 32'd0);
        check("first_handshake_ready", 32'(in_ready), 32'd1);

        // Basic values, single-cycle valid
        accept(16'd0);
        finish("zero", 20'h00000, 1'b0);
        tick();
        check("zero_valid_one_cycle", 32'(out_valid), 32'd0);
        accept(16'd10);
        finish("ten", 20'h00010, 1'b0);
        tick();
        check("ten_valid_one_cycle", 32'(out_valid), 32'd0);
        accept(16'd65535);
`ifdef BIN2BCD_SIGNED_EN
        finish("ffff", 20'h00001, 1'b1);
`else
        finish("ffff", 20'h65535, 1'b0);
`endif
        tick();
        check("ffff_valid_one_cycle", 32'(out_valid), 32'd0);

        // Backpressure: result held bit-identical for 10 cycles
        out_ready = 1'b0;
        accept(16'd4321);
        finish("bp", 20'h04321, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_bcd", 32'(out_bcd), 32'h04321);
            check("bp_hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_bcd_retained", 32'(out_bcd), 32'h04321);

        // Abort at shift cycle 7
        accept(16'd12345);
        tick(7);
        rst_n = 1'b0;
        #1;
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_bcd_cleared", 32'(out_bcd), 32'h0);
        #1;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check("abort_no_valid", 32'(seen), 32'd0);
        accept(16'd999);
        finish("after_abort", 20'h00999, 1'b0);
        tick();

        // Input ignored while busy; DONE+in_valid accepts only once back in IDLE
        accept(16'd1234);
        in_bin   = 16'd4321;
        in_valid = 1'b1;
        tick(3);
        check("busy_no_accept", 32'(in_ready), 32'd0);
        tick(12);
        check("busy_not_early", 32'(out_valid), 32'd0);
        tick();
        check("busy_valid", 32'(out_valid), 32'd1);
        check("busy_bcd_first_value", 32'(out_bcd), 32'h01234);
        tick();
        check("done_hs_valid", 32'(out_valid), 32'd0);
        check("done_hs_idle", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("idle_accept_next", 32'(in_ready), 32'd0);
        finish("second", 20'h04321, 1'b0);
        tick();

`ifdef BIN2BCD_SIGNED_EN
        accept(16'h8000);
        finish("s_min", 20'h32768, 1'b1);
        tick();
        accept(16'hFFFF);
        finish("s_m1", 20'h00001, 1'b1);
        tick();
        accept(16'h7FFF);
        finish("s_max", 20'h32767, 1'b0);
        tick();
`endif

        // Back-to-back random stream
        for (int i = 0; i < 100; i++) begin
            v = 16'($urandom_range(0, 65535));
            r = ref_conv(64'(v), 16);
            accept(v);
            finish("rand", r[19:0], r[20]);
            tick();
            check("rand_idle", 32'(in_ready), 32'd1);
        end

        // 4-bit / 2-digit sweep
        for (int i = 0; i < 16; i++) begin
            r = ref_conv(64'(i), 4);
            s_in_bin   = 4'(i);
            s_in_valid = 1'b1;
            tick();
            s_in_valid = 1'b0;
            check("w4_accept", 32'(s_in_ready), 32'd0);
            tick(3);
            check("w4_not_early", 32'(s_out_valid), 32'd0);
            tick();
            check("w4_valid", 32'(s_out_valid), 32'd1);
            check("w4_bcd", 32'(s_out_bcd), 32'(r[7:0]));
            check("w4_neg", 32'(s_out_neg), 32'(r[20]));
            tick();
        end
        check("w4_spot_15", 32'(s_out_bcd), 32'(
`ifdef BIN2BCD_SIGNED_EN
            8'h01
`else
            8'h15
`endif
        ));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Parametrised, multi-cycle binary-to-BCD converter for the display and number-formatting path. It accepts one BIN_W-bit unsigned value through a valid/ready handshake. It converts the value with the shift-and-add-3 (double-dabble) algorithm, one input bit per clock. It presents DIGITS packed BCD digits through a second valid/ready handshake, holding the result under backpressure.

## Interface
- BIN_W, default 16: width of the binary input, 1 to 32.
- DIGITS, default 5: number of BCD output digits. 10^DIGITS must exceed 2^BIN_W - 1; any other combination is an elaboration error.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  in_bin is valid.
- in_ready  out  1  block can accept an input; high only in IDLE.
- in_bin  in  BIN_W  binary value to convert.
- out_valid  out  1  out_bcd holds a completed result.
- out_ready  in  1  consumer accepts the result.
- out_bcd  out  4*DIGITS  packed BCD; digit k occupies bits [4k+3:4k], and digit 0 is the units digit.
- out_neg  out  1  sign of the result. It exists only with BIN2BCD_SIGNED_EN and is tied to 0 otherwise.

## Operation
- The FSM has three states: IDLE, SHIFT and DONE.
- **IDLE.** in_ready = 1. When in_valid && in_ready:
  - latch in_bin into the shift register;
  - clear the working BCD register;
  - load the bit counter with BIN_W;
  - go to SHIFT.
- **SHIFT.** Each cycle:
  - every working digit >= 5 first gets +3 (4-bit add, no carry between digits);
  - the concatenation {bcd, shift} then shifts left by one;
  - the bit counter decrements.
  - The cycle in which the counter reaches 0 moves the final working value into out_bcd, sets out_valid and goes to DONE.
- **DONE.** out_valid = 1. out_bcd and out_neg are held stable. When out_ready is high, out_valid clears and the FSM goes to IDLE.
- in_valid is ignored outside IDLE. There is no queuing and no input buffer.
- out_bcd keeps the last result after the handshake, until the next DONE entry overwrites it.
- Digit values never exceed 9 and unused high digits read 0.

## Timing
- Reset (asynchronous, rst_n = 0) sets:
  - FSM to IDLE;
  - out_valid = 0, out_bcd = 0, out_neg = 0;
  - working registers and counter to 0.
- in_ready is combinational from the state, so it reads 1 during and after reset.
- Latency: input accepted at edge E; out_valid goes high after edge E + BIN_W.
- Minimum input-to-input period with out_ready tied high is BIN_W + 2 cycles: accept, BIN_W shifts, output handshake, then IDLE.
- Reset asserted mid-conversion aborts it immediately. No partial result is ever flagged valid.
- out_valid held under backpressure for N cycles keeps out_bcd bit-identical for all N cycles.
- Simultaneous in_valid while in DONE with out_ready high: the output handshake completes. The input is accepted only on the following cycle, once in IDLE.

## Configuration
- **BIN2BCD_SIGNED_EN defined:**
  - in_bin is two's complement.
  - On accept, the block latches the magnitude (|in_bin|, computed in BIN_W+1 bits so that -2^(BIN_W-1) is exact) and records out_neg = in_bin[BIN_W-1].
  - The conversion runs BIN_W cycles, as in the unsigned case.
  - out_neg is registered alongside out_bcd.
- **BIN2BCD_SIGNED_EN undefined:**
  - in_bin is unsigned.
  - out_neg is a constant 0.
  - No magnitude logic is present.

## Test plan
All scenarios use BIN_W = 16, DIGITS = 5 unless stated.
- **Reset.** Hold rst_n low for 3 cycles with in_valid = 1 → in_ready = 1, out_valid = 0, out_bcd = 0x00000. Release → the first accept occurs on the next edge.
- **Basic values, out_ready = 1.**
  - 0 → out_bcd = 0x00000;
  - 10 → out_bcd = 0x00010;
  - 65535 → out_bcd = 0x65535.
  - In each case out_valid rises exactly 16 cycles after the accept edge and is high for 1 cycle.
- **Backpressure.** Convert 4321 with out_ready = 0 for 10 cycles → out_valid and out_bcd = 0x04321 stable for all 10 cycles; in_ready = 0 throughout. Raise out_ready → in_ready = 1 on the next cycle.
- **Abort.** Pulse rst_n low at shift cycle 7 of converting 12345 → out_valid stays 0. A fresh conversion of 999 then yields 0x00999.
- **Input ignored while busy.** Change in_bin and hold in_valid during SHIFT → no second accept; the result matches the first value. Back-to-back stream of 100 random values → each result matches a decimal reference model.
- **Signed, with BIN2BCD_SIGNED_EN.**
  - -32768 → out_neg = 1, out_bcd = 0x32768;
  - -1 → out_neg = 1, out_bcd = 0x00001;
  - 32767 → out_neg = 0, out_bcd = 0x32767.
  - Repeat the unsigned sweep with BIN_W = 4, DIGITS = 2: inputs 0..15 → 0x00..0x15.
